// File: rtl/uart_receive.sv
// Parametrised UART receiver (data/parity/stop configurable); UART_RECEIVE_MAJORITY_EN adds 2-of-3 bit voting.
// Latency: stb one cycle after the last stop sample; stb held until rdy, frames arriving meanwhile are dropped and flagged on ovr.
module uart_receive #(
  parameter int BAUD      = 9600,
  parameter int FREQ      = 12000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rdy,
  output logic                 stb,
  output logic [DATA_BITS-1:0] dat,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovr
);
  localparam int PERIOD = FREQ / BAUD;
  localparam int HALF   = PERIOD / 2;
  localparam int CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic          SLAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

  state_t               state;
  logic                 s1, rs;
  logic [CW-1:0]        count;
  logic [3:0]           bidx;
  logic                 sidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_int, ferr_int, done;
  logic                 smp, bitv;

`ifdef UART_RECEIVE_MAJORITY_EN
  localparam logic [CW-1:0] V0  = CW'(HALF - 2);
  localparam logic [CW-1:0] V1  = CW'(HALF - 1);
  localparam logic [CW-1:0] DEC = CW'(HALF);
  logic v0, v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (count == V0) v0 <= rs;
      if (count == V1) v1 <= rs;
    end
  end

  assign smp  = (state != S_IDLE) && (state != S_WAIT) && (count == DEC);
  assign bitv = (v0 & v1) | (v0 & rs) | (v1 & rs);
`else
  assign smp  = (state != S_IDLE) && (state != S_WAIT) && (count == CW'(HALF - 1));
  assign bitv = rs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      rs       <= 1'b1;
      state    <= S_IDLE;
      count    <= '0;
      bidx     <= '0;
      sidx     <= 1'b0;
      shreg    <= '0;
      perr_int <= 1'b0;
      ferr_int <= 1'b0;
      done     <= 1'b0;
      stb      <= 1'b0;
      dat      <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      s1   <= rxd;
      rs   <= s1;
      done <= 1'b0;

      if (state == S_IDLE || state == S_WAIT) count <= '0;
      else count <= (count == LAST) ? '0 : count + 1'b1;

      case (state)
        S_IDLE: if (!rs) state <= S_START;
        S_START: if (smp) begin
          if (bitv) begin
            state <= S_IDLE;
          end else begin
            state    <= S_DATA;
            bidx     <= '0;
            perr_int <= 1'b0;
            ferr_int <= 1'b0;
          end
        end
        S_DATA: if (smp) begin
          shreg <= {bitv, shreg[DATA_BITS-1:1]};
          bidx  <= bidx + 1'b1;
          if (bidx == DLAST) begin
            state <= (PARITY != 0) ? S_PARITY : S_STOP;
            sidx  <= 1'b0;
          end
        end
        S_PARITY: if (smp) begin
          // odd mode folds in a constant 1 so a correct frame xors to zero either way
          perr_int <= ^{shreg, bitv, (PARITY == 1)};
          state    <= S_STOP;
        end
        S_STOP: if (smp) begin
          ferr_int <= ferr_int | ~bitv;
          sidx     <= sidx + 1'b1;
          if (sidx == SLAST) begin
            done  <= 1'b1;
            state <= (ferr_int | ~bitv) ? S_WAIT : S_IDLE;
          end
        end
        S_WAIT: if (rs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (done) begin
        if (!stb || rdy) begin
          dat  <= shreg;
          perr <= perr_int;
          ferr <= ferr_int;
          stb  <= 1'b1;
          if (stb) ovr <= 1'b0;
        end else begin
          ovr <= 1'b1;
        end
      end else if (stb && rdy) begin
        stb <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive (8 data bits, even parity, 2 stop bits, PERIOD=10): directed cases plus random frames
// against a queue of expected words derived from the bits put on the line.
module tb_uart_receive;
  localparam int FREQ = 1152000, BAUD = 115200, PERIOD = FREQ / BAUD;
  localparam int DB = 8, PAR = 2, SB = 2;

  typedef struct packed {
    logic [DB-1:0] dat;
    logic          perr;
    logic          ferr;
  } word_t;

  logic clk = 1'b0;
  logic rst_n, rxd, rdy, stb, perr, ferr, ovr;
  logic [DB-1:0] dat;

  int n_vec = 0, n_err = 0, n_words = 0, cap_len = 0, hi_len = 0;
  logic [DB-1:0] cap_dat;
  logic cap_perr, cap_ferr, cap_ovr;
  word_t expq[$];

  uart_receive #(.BAUD(BAUD), .FREQ(FREQ), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rdy(rdy), .stb(stb),
    .dat(dat), .perr(perr), .ferr(ferr), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (PERIOD) tick();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Even parity: a correct parity bit makes the count of ones over data+parity even.
  task automatic send_frame(input logic [DB-1:0] d, input logic bad_par, input logic s0, input logic s1,
                            input logic expect_word);
    word_t w;
    w.dat  = d;
    w.perr = bad_par;
    w.ferr = !(s0 && s1);
    if (expect_word) expq.push_back(w);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit((^d) ^ bad_par);
    drive_bit(s0);
    drive_bit(s1);
  endtask

  // Per-cycle compare: every new word must match the queue head; otherwise outputs follow the handshake rules.
  initial begin
    word_t w, cur;
    logic p_stb, p_rdy, p_ovr;
    cur = '0; p_stb = 1'b0; p_rdy = 1'b0; p_ovr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_stb", 32'(stb), 0);
        chk("rst_dat", 32'(dat), 0);
        chk("rst_ovr", 32'(ovr), 0);
        p_stb = 1'b0; p_rdy = 1'b0; p_ovr = 1'b0; cur = '0; hi_len = 0;
      end else begin
        if (stb && !p_stb) begin
          n_words++;
          cap_dat = dat; cap_perr = perr; cap_ferr = ferr; cap_ovr = ovr;
          hi_len = 0;
          if (expq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_stb: dat %0h presented, no frame expected", dat);
          end else begin
            w = expq.pop_front();
            chk("word_dat", 32'(dat), 32'(w.dat));
            chk("word_perr", 32'(perr), 32'(w.perr));
            chk("word_ferr", 32'(ferr), 32'(w.ferr));
            cur = w;
          end
          chk("load_ovr", 32'(ovr), 0);
        end else if (p_stb && p_rdy) begin
          chk("hs_stb", 32'(stb), 0);
          chk("hs_ovr", 32'(ovr), 0);
          cap_len = hi_len;
        end else if (p_stb) begin
          chk("hold_stb", 32'(stb), 1);
          chk("hold_dat", 32'(dat), 32'(cur.dat));
          chk("hold_perr", 32'(perr), 32'(cur.perr));
          chk("hold_ferr", 32'(ferr), 32'(cur.ferr));
          if (p_ovr) chk("ovr_sticky", 32'(ovr), 1);
        end else begin
          chk("idle_ovr", 32'(ovr), 0);
          chk("idle_dat", 32'(dat), 32'(cur.dat));
        end
        if (stb) hi_len++;
        p_stb = stb; p_rdy = rdy; p_ovr = ovr;
      end
    end
  end

  initial begin
    int base;
    logic [DB-1:0] d;
    logic bp, s0, s1;
    rst_n = 1'b0; rxd = 1'b1; rdy = 1'b1;
    repeat (4) tick();
    chk("reset_stb", 32'(stb), 0);
    chk("reset_perr", 32'(perr), 0);
    chk("reset_ferr", 32'(ferr), 0);
    rst_n = 1'b1;
    idle(20);

    // single word, one-cycle strobe
    base = n_words;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t1_count", n_words - base, 1);
    chk("t1_dat", 32'(cap_dat), 32'h0000_00A5);
    chk("t1_flags", {29'd0, cap_perr, cap_ferr, cap_ovr}, 0);
    chk("t1_len", cap_len, 1);

    // parity error, then parity correct
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t2_dat", 32'(cap_dat), 32'h0000_0003);
    chk("t2_perr1", 32'(cap_perr), 1);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t2_perr0", 32'(cap_perr), 0);

    // framing error followed by a stuck-low line
    base = n_words;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    rxd = 1'b0;
    repeat (30) tick();
    chk("t3_count", n_words - base, 1);
    chk("t3_dat", 32'(cap_dat), 32'h0000_0055);
    chk("t3_ferr", 32'(cap_ferr), 1);
    idle(PERIOD);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t3_next", 32'(cap_dat), 32'h0000_003C);
    chk("t3_count2", n_words - base, 2);

    // overrun while consumer stalls
    rdy = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(5);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    chk("t4_stb", 32'(stb), 1);
    chk("t4_dat", 32'(dat), 32'h0000_0011);
    chk("t4_ovr", 32'(ovr), 1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("t4_stb_clr", 32'(stb), 0);
    chk("t4_ovr_clr", 32'(ovr), 0);
    rdy = 1'b1;
    idle(10);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t4_dat2", 32'(cap_dat), 32'h0000_0033);
    chk("t4_ovr2", 32'(cap_ovr), 0);

    // short glitch is rejected as a false start
    base = n_words;
    rxd = 1'b0;
    repeat (3) tick();
    idle(2 * PERIOD);
    chk("t5_glitch", n_words - base, 0);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t5_dat", 32'(cap_dat), 32'h0000_007E);

    // reset mid-frame with a word held and ovr set
    rdy = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(5);
    send_frame(8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    chk("t6_pre_ovr", 32'(ovr), 1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h41 >> i));
    rxd = 1'b0;
    repeat (PERIOD / 2) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async", {27'd0, stb, perr, ferr, ovr, |dat}, 0);
    rxd = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    idle(2 * PERIOD);
    base = n_words;
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t6_count", n_words - base, 1);
    chk("t6_dat", 32'(cap_dat), 32'h0000_0041);
    chk("t6_flags", {30'd0, cap_perr, cap_ferr}, 0);

    // random frames, random errors and gaps
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 5) != 0);
      s1 = ($urandom_range(0, 5) != 0);
      send_frame(d, bp, s0, s1, 1'b1);
      idle($urandom_range(0, 12) + (s1 ? 0 : PERIOD));
    end

    for (int i = 0; i < 500 && expq.size() != 0; i++) tick();
    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
